// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-network front end.
//   - snn_state_t : frame-loader FSM states
//   - SNN_WORD_W, SNN_CHUNK_WORDS : default JTAG word width and words/chunk
//   - ceil_div    : integer ceiling division, used to size the chunk count
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int SNN_WORD_W      = 32;
    localparam int SNN_CHUNK_WORDS = 14;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WAIT   = 3'd2,
        SETTLE = 3'd3,
        START  = 3'd4,
        RUN    = 3'd5
    } snn_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer for a level signal arriving from another clock
// domain, plus a one-cycle rising-edge pulse on the synchronized copy.
// Ports:
//   iCLK   in  destination clock
//   iRESET in  synchronous, active-high reset (clears all three flops)
//   iASYNC in  asynchronous level input
//   oSYNC  out synchronized level (2 flops after iASYNC)
//   oRISE  out high for one cycle when oSYNC goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iASYNC,
    output logic oSYNC,
    output logic oRISE
);

    logic meta;
    logic synced;
    logic syncedPrev;

    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the two synchronizer stages into one.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            meta       <= 1'b0;
            synced     <= 1'b0;
            syncedPrev <= 1'b0;
        end else begin
            meta       <= iASYNC;
            synced     <= meta;
            syncedPrev <= synced;
        end
    end

    assign oSYNC = synced;
    assign oRISE = synced & ~syncedPrev;

endmodule

// File: rtl/snn_frame_loader.sv
// ---------------------------------------------------------------------------
// snn_frame_loader
// Assembles an image written by the host over JTAG, one chunk of
// WORDS_PER_CHUNK words at a time, into a flat NUM_PIXELS-bit vector. The
// final chunk of a frame (iFINISH high with iNEXT) starts the network with a
// one-cycle oSTART pulse, then holds oRUN_EN high until the next frame.
//
// Ports:
//   iCLK        in  system clock (wCLK8 domain)
//   iRESET      in  synchronous, active-high reset; discards any partial frame
//   iWORDS      in  chunk data, word i at [i*WORD_W +: WORD_W], stable while iNEXT high
//   iNEXT       in  host chunk strobe (async level); rising edge = chunk valid
//   iFINISH     in  host flag; high with iNEXT marks the last chunk of a frame
//   oPIXELS     out assembled image, 1 bit per pixel
//   oSTART      out one-cycle start pulse to the network
//   oRUN_EN     out spike-clock enable
//   oCHUNK_IDX  out index of the next chunk expected
//   oERR        out sticky: chunk beyond the image, or strobe while busy
//
// Build option:
//   SNN_FRAME_CLEAR_EN  when defined, the first chunk of each frame also
//                       zeroes the whole image so short frames start clean.
// ---------------------------------------------------------------------------
module snn_frame_loader
    import snn_pkg::*;
#(
    parameter int WORD_W          = SNN_WORD_W,
    parameter int WORDS_PER_CHUNK = SNN_CHUNK_WORDS,
    parameter int NUM_PIXELS      = 800,
    parameter int SETTLE_CYC      = 1
) (
    input  logic                              iCLK,
    input  logic                              iRESET,
    input  logic [WORDS_PER_CHUNK*WORD_W-1:0] iWORDS,
    input  logic                              iNEXT,
    input  logic                              iFINISH,
    output logic [NUM_PIXELS-1:0]             oPIXELS,
    output logic                              oSTART,
    output logic                              oRUN_EN,
    output logic [4:0]                        oCHUNK_IDX,
    output logic                              oERR
);

    localparam int CHUNK_BITS = WORDS_PER_CHUNK * WORD_W;
    localparam int MAX_CHUNKS = ceil_div(NUM_PIXELS, CHUNK_BITS);
    localparam int IDX_W      = 5;
    localparam int CNT_W      = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

    snn_state_t             state;
    snn_state_t             nextState;
    logic [CNT_W-1:0]       settleCnt;
    logic [IDX_W-1:0]       chunkIdx;
    logic [NUM_PIXELS-1:0]  pixels;
    logic [NUM_PIXELS-1:0]  chunkPixels;
    logic                   err;
    logic                   startPulse;
    logic                   runEn;
    logic                   finishLatched;
    logic                   nextRise;
    logic                   nextSyncUnused;
    logic                   finishSync;
    logic                   finishRiseUnused;
    logic                   edgeAccept;
    logic                   edgeBusy;
    logic                   overflow;

    sync_edge_det uNextSync (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iASYNC (iNEXT),
        .oSYNC  (nextSyncUnused),
        .oRISE  (nextRise)
    );

    // Only the level is needed for FINISH; it is sampled in the NEXT edge cycle.
    sync_edge_det uFinishSync (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iASYNC (iFINISH),
        .oSYNC  (finishSync),
        .oRISE  (finishRiseUnused)
    );

    assign edgeAccept = nextRise && (state == IDLE || state == WAIT || state == RUN);
    assign edgeBusy   = nextRise && (state == SETTLE || state == START);
    // A chunk whose base bit lies past the image cannot land anywhere.
    assign overflow   = (chunkIdx >= IDX_W'(MAX_CHUNKS));

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, WAIT, RUN: if (nextRise) nextState = LOAD;
            LOAD:            nextState = finishLatched ? SETTLE : WAIT;
            SETTLE:          if (settleCnt == CNT_W'(SETTLE_CYC - 1)) nextState = START;
            START:           nextState = RUN;
            default:         nextState = IDLE;
        endcase
    end

`ifdef SNN_FRAME_CLEAR_EN
    logic clearPending;
`endif

    // Image after writing the current chunk. Each pixel belongs to exactly
    // one chunk slot; pixels past NUM_PIXELS simply have no slot, which drops
    // the tail of the last chunk.
    always_comb begin
        chunkPixels = pixels;
`ifdef SNN_FRAME_CLEAR_EN
        if (clearPending) chunkPixels = '0;
`endif
        for (int p = 0; p < NUM_PIXELS; p++) begin
            if (chunkIdx == IDX_W'(p / CHUNK_BITS)) chunkPixels[p] = iWORDS[p % CHUNK_BITS];
        end
    end

    // NOTE: the pixel vector is a plain register bank, not a RAM, so it is
    // reset with everything else and reads all-zero after reset.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state         <= IDLE;
            settleCnt     <= '0;
            chunkIdx      <= '0;
            pixels        <= '0;
            err           <= 1'b0;
            startPulse    <= 1'b0;
            runEn         <= 1'b0;
            finishLatched <= 1'b0;
        end else begin
            state      <= nextState;
            startPulse <= (state == START);
            // Drops on the same edge that a new frame's chunk moves RUN -> LOAD.
            runEn      <= (nextState == RUN);

            if (edgeAccept) finishLatched <= finishSync;
            if (edgeBusy)   err <= 1'b1;

            if (state == LOAD) begin
                settleCnt <= '0;
                if (overflow) err <= 1'b1;
                else          pixels <= chunkPixels;
                // A final chunk always closes the frame, even an overflowing one.
                if (finishLatched)  chunkIdx <= '0;
                else if (!overflow) chunkIdx <= chunkIdx + 1'b1;
            end

            if (state == SETTLE) settleCnt <= settleCnt + 1'b1;
        end
    end

`ifdef SNN_FRAME_CLEAR_EN
    // Clear only for the first chunk of a frame, i.e. one entered from IDLE or RUN.
    always_ff @(posedge iCLK) begin
        if (iRESET)          clearPending <= 1'b0;
        else if (edgeAccept) clearPending <= (state != WAIT);
    end
`endif

    assign oPIXELS    = pixels;
    assign oSTART     = startPulse;
    assign oRUN_EN    = runEn;
    assign oCHUNK_IDX = chunkIdx;
    assign oERR       = err;

endmodule

// File: tb/tb_snn_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_snn_frame_loader
// Scoreboarded bench for snn_frame_loader. Stimulus tasks drive chunks and
// push expected output snapshots (keyed by clock cycle) and expected oSTART
// cycles into queues; a monitor on the falling edge pops and compares.
// The reference model works on whole chunks: base = idx * 448, bits past 800
// dropped, timing derived from the 4-cycle strobe-to-write latency.
// ---------------------------------------------------------------------------
module tb_snn_frame_loader;

    localparam int WORD_W = 32;
    localparam int WPC    = 14;
    localparam int NPIX   = 800;
    localparam int SETTLE = 4;
    localparam int CB     = WORD_W * WPC;

    logic            iCLK = 1'b0;
    logic            iRESET = 1'b1;
    logic [CB-1:0]   iWORDS = '0;
    logic            iNEXT = 1'b0;
    logic            iFINISH = 1'b0;
    logic [NPIX-1:0] oPIXELS;
    logic            oSTART;
    logic            oRUN_EN;
    logic [4:0]      oCHUNK_IDX;
    logic            oERR;

    snn_frame_loader #(
        .WORD_W          (WORD_W),
        .WORDS_PER_CHUNK (WPC),
        .NUM_PIXELS      (NPIX),
        .SETTLE_CYC      (SETTLE)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iWORDS     (iWORDS),
        .iNEXT      (iNEXT),
        .iFINISH    (iFINISH),
        .oPIXELS    (oPIXELS),
        .oSTART     (oSTART),
        .oRUN_EN    (oRUN_EN),
        .oCHUNK_IDX (oCHUNK_IDX),
        .oERR       (oERR)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int              due;
        logic [NPIX-1:0] pix;
        logic [4:0]      idx;
        logic            err;
        logic            run;
    } exp_t;

    exp_t expQ[$];
    int   startQ[$];
    int   nChecks = 0;
    int   nPass   = 0;

    // Reference model state
    logic [NPIX-1:0] mPix = '0;
    int              mIdx = 0;
    logic            mErr = 1'b0;
    int              lastW = -1000;

    task automatic check(input string name, input logic [NPIX-1:0] act, input logic [NPIX-1:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input int due, input logic run);
        exp_t e;
        e.due = due;
        e.pix = mPix;
        e.idx = 5'(mIdx);
        e.err = mErr;
        e.run = run;
        expQ.push_back(e);
    endtask

    // Monitor: compare snapshots and start pulses on the falling edge.
    exp_t cur;
    bit   checkRunNext = 1'b0;
    always @(negedge iCLK) begin
        if (checkRunNext) begin
            check("run_en_after_start", oRUN_EN, 1'b1);
            checkRunNext = 1'b0;
        end
        if (oSTART === 1'b1) begin
            if (startQ.size() == 0) begin
                nChecks++;
                $display("FAIL start_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                check("start_cycle", cyc, startQ.pop_front());
                checkRunNext = 1'b1;
            end
        end
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            cur = expQ.pop_front();
            check($sformatf("pixels@%0d", cyc), oPIXELS, cur.pix);
            check($sformatf("chunk_idx@%0d", cyc), oCHUNK_IDX, cur.idx);
            check($sformatf("err@%0d", cyc), oERR, cur.err);
            check($sformatf("run_en@%0d", cyc), oRUN_EN, cur.run);
        end
    end

    task automatic do_reset();
        int r;
        @(posedge iCLK); #1;
        iRESET = 1'b1;
        iNEXT = 1'b0;
        iFINISH = 1'b0;
        r = cyc;
        mPix = '0;
        mIdx = 0;
        mErr = 1'b0;
        lastW = -1000;
        startQ.delete();
        push_exp(r + 1, 1'b0);
        push_exp(r + 2, 1'b0);
        repeat (2) @(posedge iCLK);
        #1 iRESET = 1'b0;
    endtask

    // Raise iNEXT on one edge k; the write lands on edge k+4.
    task automatic send_chunk(input logic [CB-1:0] words, input logic fin, input int hi, input int lo);
        int k;
        bit busy;
        bit ovf;
        @(posedge iCLK); #1;
        iWORDS = words;
        iFINISH = fin;
        iNEXT = 1'b1;
        k = cyc;
        // Controller state during the edge cycle is SETTLE/START for writes
        // at lastW..lastW+SETTLE.
        busy = (lastW <= k + 2) && (k + 2 <= lastW + SETTLE);
        if (busy) begin
            mErr = 1'b1;
            push_exp(k + 3, (k + 3) >= lastW + SETTLE + 1);
            push_exp(k + 4, (k + 4) >= lastW + SETTLE + 1);
        end else begin
            push_exp(k + 3, 1'b0);
            ovf = (mIdx * CB >= NPIX);
            if (ovf) begin
                mErr = 1'b1;
            end else begin
`ifdef SNN_FRAME_CLEAR_EN
                if (mIdx == 0) mPix = '0;
`endif
                for (int b = 0; b < CB; b++) begin
                    if (mIdx * CB + b < NPIX) mPix[mIdx * CB + b] = words[b];
                end
            end
            if (fin) begin
                mIdx = 0;
                lastW = k + 4;
                startQ.push_back(k + 4 + SETTLE + 1);
            end else if (!ovf) begin
                mIdx++;
            end
            push_exp(k + 4, 1'b0);
        end
        repeat (hi) @(posedge iCLK);
        #1 iNEXT = 1'b0;
        repeat (lo) @(posedge iCLK);
    endtask

    function automatic logic [CB-1:0] fill(input logic [31:0] w);
        logic [CB-1:0] v;
        for (int i = 0; i < WPC; i++) v[i*WORD_W +: WORD_W] = w;
        return v;
    endfunction

    function automatic logic [CB-1:0] rand_words();
        logic [CB-1:0] v;
        for (int i = 0; i < WPC; i++) v[i*WORD_W +: WORD_W] = $urandom;
        return v;
    endfunction

    initial begin
        logic [CB-1:0] one;
        int nch;
        one = '0;
        one[0] = 1'b1;

        do_reset();

        // Two-chunk frame: all-ones then A5 pattern with FINISH.
        send_chunk(fill(32'hFFFFFFFF), 1'b0, 5, 4);
        send_chunk(fill(32'hA5A5A5A5), 1'b1, 5, 4);

        // Single-chunk frame with FINISH on the first chunk.
        send_chunk(one, 1'b1, 5, 4);

        // Three non-final chunks: the third starts past the image.
        send_chunk(rand_words(), 1'b0, 5, 4);
        send_chunk(rand_words(), 1'b0, 5, 4);
        send_chunk(rand_words(), 1'b0, 5, 4);
        do_reset();

        // Reset in the middle of a frame; next chunk lands at index 0.
        send_chunk(rand_words(), 1'b0, 5, 4);
        do_reset();
        send_chunk(rand_words(), 1'b1, 5, 4);

        // Strobe while settling: ignored, flags an error, one start only.
        send_chunk(rand_words(), 1'b1, 2, 2);
        send_chunk(rand_words(), 1'b1, 5, 4);
        repeat (6) @(posedge iCLK);
        do_reset();

        // All-ones frame, then a short all-zero frame.
        send_chunk(fill(32'hFFFFFFFF), 1'b0, 5, 4);
        send_chunk(fill(32'hFFFFFFFF), 1'b1, 5, 4);
        send_chunk('0, 1'b1, 5, 4);

        // Random frames of one or two chunks with random gaps.
        for (int f = 0; f < 10; f++) begin
            nch = $urandom_range(1, 2);
            for (int c = 0; c < nch; c++) begin
                send_chunk(rand_words(), c == nch - 1, $urandom_range(3, 6), $urandom_range(5, 7));
            end
        end

        repeat (20) @(posedge iCLK);
        #1;
        check("scoreboard_drained", expQ.size(), 0);
        check("starts_drained", startQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
        $fatal(1);
    end

endmodule
